seg_block_counter: RTL and testbench

//  Mode-controller stage that accepts a segment header (byte length) and tracks the segment as the datapath consumes 128-bit blocks.

---
 rtl/spook_mode_pkg.sv | 17 +
 rtl/seg_rem_cnt.sv | 36 +++
 rtl/seg_block_counter.sv | 140 ++++++++++++++
 tb/tb_seg_block_counter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spook_mode_pkg.sv
// Shared constants for the spook mode controller: block size and the
// segment-tracker state encoding.
package spook_mode_pkg;

    localparam int BLK_BYTES = 16;

    localparam logic [1:0] SEG_IDLE   = 2'd0;
    localparam logic [1:0] SEG_ACTIVE = 2'd1;
    localparam logic [1:0] SEG_DONE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = SEG_IDLE,
        ST_ACTIVE = SEG_ACTIVE,
        ST_DONE   = SEG_DONE
    } seg_state_t;

endpackage

// File: rtl/seg_rem_cnt.sv
// Loadable down-counter of the bytes still to be consumed in the current
// segment, with the two range flags the segment tracker decides on.
module seg_rem_cnt
    import spook_mode_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_load_val,
    input  logic             i_dec,
    input  logic [4:0]       i_dec_val,
    output logic [LEN_W-1:0] o_rem,
    output logic             o_le16,
    output logic             o_nz
);

    logic [LEN_W-1:0] r_rem;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_load_val;
        end else if (i_dec) begin
            r_rem <= r_rem - LEN_W'(i_dec_val);
        end
    end

    assign o_rem  = r_rem;
    assign o_le16 = (r_rem <= LEN_W'(BLK_BYTES));
    assign o_nz   = (r_rem != '0);

endmodule

// File: rtl/seg_block_counter.sv
// Segment block counter: tracks a segment across 16-byte blocks and pulses the
// last/padding flag set/unset lines. Optional sticky err port with SEG_CNT_ERR_EN.
module seg_block_counter
    import spook_mode_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hdr_valid,
    output logic             hdr_ready,
    input  logic [LEN_W-1:0] hdr_len,
    input  logic             blk_consume,
    output logic             busy,
    output logic [4:0]       blk_bytes,
    output logic             is_last,
    output logic             syn_set_last,
    output logic             syn_unset_last,
    output logic             syn_set_pad,
    output logic             syn_unset_pad,
    output logic             seg_done
`ifdef SEG_CNT_ERR_EN
    ,
    output logic             err
`endif
);

    seg_state_t       r_state;
    logic             r_set_last;
    logic             r_unset_last;
    logic             r_set_pad;
    logic             r_unset_pad;
    logic             r_seg_done;

    logic             w_active;
    logic             w_load;
    logic             w_dec;
    logic [LEN_W-1:0] w_rem;
    logic             w_le16;
    logic             w_nz;
    logic             w_next_le16;
    logic [4:0]       w_blk_bytes;
    logic             w_is_last;

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_load      = hdr_valid & (r_state == ST_IDLE);
    assign w_dec       = blk_consume & w_active;
    assign w_blk_bytes = w_active ? (w_le16 ? w_rem[4:0] : 5'(BLK_BYTES)) : 5'd0;
    assign w_is_last   = w_active & w_le16 & w_nz;
    // Only consulted when a full block is being consumed, so rem-16 <= 16.
    assign w_next_le16 = (w_rem <= LEN_W'(2 * BLK_BYTES));

    seg_rem_cnt #(
        .LEN_W (LEN_W)
    ) u_rem_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (hdr_len),
        .i_dec      (w_dec),
        .i_dec_val  (w_blk_bytes),
        .o_rem      (w_rem),
        .o_le16     (w_le16),
        .o_nz       (w_nz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_set_last   <= 1'b0;
            r_unset_last <= 1'b0;
            r_set_pad    <= 1'b0;
            r_unset_pad  <= 1'b0;
            r_seg_done   <= 1'b0;
        end else begin
            r_set_last   <= 1'b0;
            r_unset_last <= 1'b0;
            r_set_pad    <= 1'b0;
            r_unset_pad  <= 1'b0;
            r_seg_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (hdr_valid) begin
                        if (hdr_len == '0) begin
                            r_state      <= ST_DONE;
                            r_seg_done   <= 1'b1;
                            r_unset_last <= 1'b1;
                            r_unset_pad  <= 1'b1;
                        end else begin
                            r_state    <= ST_ACTIVE;
                            r_set_last <= (hdr_len <= LEN_W'(BLK_BYTES));
                            r_set_pad  <= (hdr_len <= LEN_W'(BLK_BYTES)) && (hdr_len[3:0] != 4'd0);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (blk_consume) begin
                        if (w_is_last) begin
                            r_state      <= ST_DONE;
                            r_seg_done   <= 1'b1;
                            r_unset_last <= 1'b1;
                            r_unset_pad  <= 1'b1;
                        end else begin
                            // A full block leaves the low nibble of rem unchanged.
                            r_set_last <= w_next_le16;
                            r_set_pad  <= w_next_le16 && (w_rem[3:0] != 4'd0);
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hdr_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign blk_bytes      = w_blk_bytes;
    assign is_last        = w_is_last;
    assign syn_set_last   = r_set_last;
    assign syn_unset_last = r_unset_last;
    assign syn_set_pad    = r_set_pad;
    assign syn_unset_pad  = r_unset_pad;
    assign seg_done       = r_seg_done;

`ifdef SEG_CNT_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (blk_consume && (!w_active || (hdr_valid && hdr_len == '0))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_seg_block_counter.sv
// Scoreboard bench for seg_block_counter: the driver predicts each segment's
// block sizes and flag pulses, a negedge monitor compares what the DUT shows.
module tb_seg_block_counter;

    localparam logic [4:0] V_SET_LAST = 5'b10000;
    localparam logic [4:0] V_SET_PAD  = 5'b00100;
    localparam logic [4:0] V_DONE     = 5'b01011;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  vec;
    } pulse_t;

    typedef struct {
        logic [4:0] bytes;
        logic       last;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [15:0] hdr_len = 16'd0;
    logic        blk_consume = 1'b0;
    logic        busy;
    logic [4:0]  blk_bytes;
    logic        is_last;
    logic        syn_set_last;
    logic        syn_unset_last;
    logic        syn_set_pad;
    logic        syn_unset_pad;
    logic        seg_done;
`ifdef SEG_CNT_ERR_EN
    logic        err;
`endif

    seg_block_counter #(
        .LEN_W (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hdr_valid      (hdr_valid),
        .hdr_ready      (hdr_ready),
        .hdr_len        (hdr_len),
        .blk_consume    (blk_consume),
        .busy           (busy),
        .blk_bytes      (blk_bytes),
        .is_last        (is_last),
        .syn_set_last   (syn_set_last),
        .syn_unset_last (syn_unset_last),
        .syn_set_pad    (syn_set_pad),
        .syn_unset_pad  (syn_unset_pad),
        .seg_done       (seg_done)
`ifdef SEG_CNT_ERR_EN
        ,
        .err            (err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_checks = 0;
    int     n_errors = 0;
    pulse_t q_pulse[$];
    blk_t   q_blk[$];
    logic   q_rdy[$];
    bit     in_done = 1'b0;
    bit     exp_err = 1'b0;

    logic [4:0] w_pulse;
    assign w_pulse = {syn_set_last, syn_unset_last, syn_set_pad, syn_unset_pad, seg_done};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT output with no expectation queued (t=%0t)", name, $time);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a pulse, a consumed block or a header.
    pulse_t mon_p;
    blk_t   mon_b;
    logic   mon_r;
    always @(negedge clk) begin
        if (!rst) begin
            if (w_pulse != 5'd0) begin
                if (q_pulse.size() == 0) begin
                    fail("pulse_unexpected");
                end else begin
                    mon_p = q_pulse.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(mon_p.cyc));
                    check("pulse_vector", 32'(w_pulse), 32'(mon_p.vec));
                end
            end
            if (blk_consume) begin
                if (q_blk.size() == 0) begin
                    fail("blk_unexpected");
                end else begin
                    mon_b = q_blk.pop_front();
                    check("blk_bytes", 32'(blk_bytes), 32'(mon_b.bytes));
                    check("is_last", 32'(is_last), 32'(mon_b.last));
                end
            end
            if (hdr_valid) begin
                if (q_rdy.size() == 0) begin
                    fail("hdr_unexpected");
                end else begin
                    mon_r = q_rdy.pop_front();
                    check("hdr_ready", 32'(hdr_ready), 32'(mon_r));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_err(input string name);
`ifdef SEG_CNT_ERR_EN
        check(name, 32'(err), 32'(exp_err));
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_hdr_ready"}, 32'(hdr_ready), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_blk_bytes"}, 32'(blk_bytes), 32'd0);
        check({name, "_is_last"}, 32'(is_last), 32'd0);
        check({name, "_pulses"}, 32'(w_pulse), 32'd0);
    endtask

    // Presents a header; if the DUT is in its DONE cycle the first attempt must be refused.
    task automatic present_hdr(input int unsigned len, output int unsigned c);
        hdr_len   = 16'(len);
        hdr_valid = 1'b1;
        if (in_done) begin
            q_rdy.push_back(1'b0);
            tick();
        end
        q_rdy.push_back(1'b1);
        tick();
        c         = cyc;
        hdr_valid = 1'b0;
        in_done   = 1'b0;
    endtask

    // Reference model: a segment of len bytes is ceil(len/16) blocks, all full but the last.
    task automatic run_seg(input int unsigned len, input int unsigned gap_max, input bit hv_noise);
        int unsigned c;
        int unsigned n;
        int unsigned gap;
        logic [4:0]  set_vec;
        present_hdr(len, c);
        n       = (len + 15) / 16;
        set_vec = ((len % 16) != 0) ? (V_SET_LAST | V_SET_PAD) : V_SET_LAST;
        if (len == 0) begin
            q_pulse.push_back('{c, V_DONE});
            in_done = 1'b1;
            return;
        end
        if (len <= 16) q_pulse.push_back('{c, set_vec});
        for (int i = 1; i <= int'(n); i++) begin
            gap = (gap_max != 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (gap) begin
                if (hv_noise && $urandom_range(1, 0) == 1) begin
                    hdr_valid = 1'b1;
                    hdr_len   = 16'($urandom);
                    q_rdy.push_back(1'b0);
                end
                tick();
                hdr_valid = 1'b0;
            end
            blk_consume = 1'b1;
            q_blk.push_back('{(i == int'(n)) ? 5'(len - 16 * (n - 1)) : 5'd16, i == int'(n)});
            tick();
            blk_consume = 1'b0;
            if (i == int'(n) - 1) q_pulse.push_back('{cyc, set_vec});
            if (i == int'(n))     q_pulse.push_back('{cyc, V_DONE});
        end
        in_done = 1'b1;
    endtask

    // Consume outside ACTIVE: ignored by the datapath, flagged by err when present.
    task automatic stray_consume();
        blk_consume = 1'b1;
        q_blk.push_back('{5'd0, 1'b0});
        exp_err = 1'b1;
        tick();
        blk_consume = 0;
        in_done     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        int unsigned len;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        check_err("rst_hold_err");
        rst = 1'b0;
        tick();
        check_reset_outputs("rst_release");

        run_seg(40, 2, 1'b1);
        run_seg(32, 1, 1'b0);
        run_seg(0, 0, 1'b0);
        run_seg(20, 0, 1'b0);

        // Reset in the middle of a short segment, before its only consume.
        present_hdr(5, c);
        q_pulse.push_back('{c, V_SET_LAST | V_SET_PAD});
        @(negedge clk);
        #1;
        check("t4_blk_bytes", 32'(blk_bytes), 32'd5);
        check("t4_is_last", 32'(is_last), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t4_rst");
        exp_err = 1'b0;
        check_err("t4_rst_err");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        in_done = 1'b0;

        stray_consume();
        check("t6_hdr_ready", 32'(hdr_ready), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check_err("t6_err_set");
        run_seg(17, 1, 1'b0);
        tick();
        in_done = 1'b0;
        check_err("t6_err_sticky");

        run_seg(65535, 0, 1'b0);

        repeat (40) begin
            case ($urandom_range(3, 0))
                0:       len = 0;
                1:       len = $urandom_range(16, 1);
                2:       len = $urandom_range(100, 17);
                default: len = $urandom_range(700, 0);
            endcase
            run_seg(len, 2, 1'b1);
            case ($urandom_range(3, 0))
                0: stray_consume();
                1: begin
                    repeat ($urandom_range(3, 1)) tick();
                    in_done = 1'b0;
                end
                default: ;
            endcase
        end

        tick();
        tick();
        check("end_busy", 32'(busy), 32'd0);
        check_err("end_err");
        rst = 1'b1;
        #1;
        exp_err = 1'b0;
        check_reset_outputs("end_rst");
        check_err("end_rst_err");
        tick();
        rst = 1'b0;
        tick();

        check("q_pulse_drained", 32'(q_pulse.size()), 32'd0);
        check("q_blk_drained", 32'(q_blk.size()), 32'd0);
        check("q_rdy_drained", 32'(q_rdy.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
